// File: rtl/fifox_rd_stream_if.sv
// fifox read port plus TX valid/ready stream, bundled for fifox_rd_stream.
// master is the stream converter's view; slave is the fifox/consumer side.
interface fifox_rd_stream_if #(
    parameter int ITEM_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
);

    localparam int SW = $clog2(BUF_DEPTH + 1);

    logic [ITEM_WIDTH-1:0] FIFO_DO;
    logic                  FIFO_RD;
    logic                  FIFO_EMPTY;
    logic                  FIFO_AEMPTY;
    logic [ITEM_WIDTH-1:0] TX_DATA;
    logic                  TX_SRC_RDY;
    logic                  TX_DST_RDY;
    logic                  TX_AEMPTY;
    logic [SW-1:0]         BUF_STATUS;

    modport master (
        input  FIFO_DO,
        input  FIFO_EMPTY,
        input  FIFO_AEMPTY,
        input  TX_DST_RDY,
        output FIFO_RD,
        output TX_DATA,
        output TX_SRC_RDY,
        output TX_AEMPTY,
        output BUF_STATUS
    );

    modport slave (
        output FIFO_DO,
        output FIFO_EMPTY,
        output FIFO_AEMPTY,
        output TX_DST_RDY,
        input  FIFO_RD,
        input  TX_DATA,
        input  TX_SRC_RDY,
        input  TX_AEMPTY,
        input  BUF_STATUS
    );

endinterface

// File: rtl/fifox_rd_stream.sv
// fifox read port to valid/ready stream converter with read-latency
// tracking and a small credit-managed output buffer.
module fifox_rd_stream #(
    parameter int ITEM_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4
) (
    input logic               CLK,
    input logic               RESET_N,
    fifox_rd_stream_if.master bus
);

    localparam int SW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [SW-1:0] cnt_t;

    localparam ptr_t PTR_LAST = ptr_t'(BUF_DEPTH - 1);
    localparam cnt_t DEPTH_C  = cnt_t'(BUF_DEPTH);
    localparam cnt_t ONE      = cnt_t'(1);

    logic [ITEM_WIDTH-1:0] mem_q [BUF_DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t cnt_q, cnt_d;
    cnt_t res_q, res_d;

    logic rd;
    logic cap;
    logic xfer;

    // res_q counts buffered plus in-flight items, so a read is only
    // issued when a slot is guaranteed for its data.
    assign rd   = !bus.FIFO_EMPTY && (res_q < DEPTH_C);
    assign xfer = (cnt_q != '0) && bus.TX_DST_RDY;

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign cap = rd;
        end else if (RD_LATENCY == 1) begin : g_lat1
            logic fl_q;
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) fl_q <= 1'b0;
                else          fl_q <= rd;
            end
            assign cap = fl_q;
        end else begin : g_latn
            logic [RD_LATENCY-1:0] fl_q;
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) fl_q <= '0;
                else          fl_q <= {fl_q[RD_LATENCY-2:0], rd};
            end
            assign cap = fl_q[RD_LATENCY-1];
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        if (cap) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ptr_t'(1);
        end
        if (xfer) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ptr_t'(1);
        end
        unique case ({cap, xfer})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
        unique case ({rd, xfer})
            2'b10:   res_d = res_q + ONE;
            2'b01:   res_d = res_q - ONE;
            default: res_d = res_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge CLK) begin
        if (cap) mem_q[wr_ptr_q] <= bus.FIFO_DO;
    end

    assign bus.FIFO_RD    = rd;
    assign bus.TX_SRC_RDY = (cnt_q != '0);
    assign bus.TX_DATA    = mem_q[rd_ptr_q];
    assign bus.TX_AEMPTY  = bus.FIFO_AEMPTY && (res_q <= ONE);
    assign bus.BUF_STATUS = cnt_q;

endmodule

// File: tb/tb_fifox_rd_stream.sv
// Scoreboard bench for fifox_rd_stream: three configurations driven by a
// behavioural fifox model, checked against timing rules and item order.
module tb_fifox_rd_stream;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int   n_chk    = 0;
    int   n_fail   = 0;
    int   target   = 0;
    int   mode     = 1;
    bit   rnd_data = 1'b0;
    int   ck_id    = 0;
    event ev_ck;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g,
                       input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [cfg%0d] at %0t: got %0d, expected %0d",
                     nm, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int LAT   = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
        localparam int DEP   = (g == 1) ? 4 : 3;
        localparam int DRAIN = (g == 0) ? 16 : ((g == 1) ? 17 : 23);

        fifox_rd_stream_if #(.ITEM_WIDTH(8), .BUF_DEPTH(DEP)) bus ();

        fifox_rd_stream #(
            .ITEM_WIDTH(8),
            .RD_LATENCY(LAT),
            .BUF_DEPTH (DEP)
        ) dut (
            .CLK    (clk),
            .RESET_N(rst_n),
            .bus    (bus)
        );

        logic [7:0] fq[$];
        logic [7:0] exq[$];
        int         rdc[$];
        logic [7:0] dly0    = '0;
        logic [7:0] dly1    = '0;
        int         n_rd    = 0;
        int         n_xf    = 0;
        int         landed  = 0;
        int         cyc     = 0;
        int         pushed  = 0;
        int         t0      = 0;
        int         last_xf = 0;
        bit         rd_s    = 1'b0;

        // fifox model and consumer: data appears RD_LATENCY cycles after a read
        initial begin
            bus.FIFO_DO     = '0;
            bus.FIFO_EMPTY  = 1'b1;
            bus.FIFO_AEMPTY = 1'b1;
            bus.TX_DST_RDY  = 1'b0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    fq.delete();
                    pushed          = 0;
                    bus.FIFO_EMPTY  = 1'b1;
                    bus.FIFO_AEMPTY = 1'b1;
                    bus.TX_DST_RDY  = 1'b0;
                    #1;
                    chk("rst_fifo_rd", g, bus.FIFO_RD, 0);
                    chk("rst_src_rdy", g, bus.TX_SRC_RDY, 0);
                    chk("rst_buf_status", g, bus.BUF_STATUS, 0);
                    chk("rst_tx_aempty", g, bus.TX_AEMPTY, 1);
                end else begin
                    #1;
                    cyc++;
                    dly1 = dly0;
                    dly0 = 8'($urandom);
                    if (rd_s && fq.size() > 0) begin
                        dly0 = fq.pop_front();
                        exq.push_back(dly0);
                    end
                    while (pushed < target) begin
                        if (pushed == 0) t0 = cyc;
                        fq.push_back(rnd_data ? 8'($urandom) : 8'(pushed + 1));
                        pushed++;
                    end
                    bus.FIFO_EMPTY  = (fq.size() == 0);
                    bus.FIFO_AEMPTY = (fq.size() <= 1);
                    if (LAT == 0)
                        bus.FIFO_DO = (fq.size() > 0) ? fq[0] : 8'($urandom);
                    else if (LAT == 1)
                        bus.FIFO_DO = dly0;
                    else
                        bus.FIFO_DO = dly1;
                    bus.TX_DST_RDY = (mode == 2) ? 1'($urandom_range(0, 1))
                                                 : (mode == 1);
                end
            end
        end

        // monitor: checks every cycle against counts of reads and transfers
        initial forever begin
            @(negedge clk);
            if (!rst_n) begin
                exq.delete();
                rdc.delete();
                n_rd   = 0;
                n_xf   = 0;
                landed = 0;
                rd_s   = 1'b0;
            end else begin : mon
                int r;
                int st;
                while (rdc.size() > 0 && rdc[0] <= cyc - LAT - 1) begin
                    void'(rdc.pop_front());
                    landed++;
                end
                r  = n_rd - n_xf;
                st = landed - n_xf;
                chk("fifo_rd", g, bus.FIFO_RD, !bus.FIFO_EMPTY && r < DEP);
                chk("reserved_le_depth", g, r <= DEP, 1);
                chk("src_rdy", g, bus.TX_SRC_RDY, st > 0);
                chk("buf_status", g, bus.BUF_STATUS, st);
                chk("tx_aempty", g, bus.TX_AEMPTY, bus.FIFO_AEMPTY && r <= 1);
                if (bus.TX_SRC_RDY) begin
                    chk("tx_pending", g, exq.size() > 0, 1);
                    if (exq.size() > 0) chk("tx_data", g, bus.TX_DATA, exq[0]);
                    if (bus.TX_DST_RDY) begin
                        if (exq.size() > 0) void'(exq.pop_front());
                        n_xf++;
                        last_xf = cyc;
                    end
                end
                if (bus.FIFO_RD) begin
                    n_rd++;
                    rdc.push_back(cyc);
                end
                rd_s = bus.FIFO_RD;
            end
        end

        initial forever begin
            @(ev_ck);
            case (ck_id)
                1: begin
                    chk("burst_drain_cycles", g, last_xf - t0, DRAIN);
                    chk("burst_count", g, n_xf, 16);
                end
                2: begin
                    chk("stall_reads", g, n_rd - 16, DEP);
                    chk("stall_status", g, bus.BUF_STATUS, DEP);
                    chk("stall_head", g, bus.TX_DATA, 8'h11);
                end
                3: chk("release_count", g, n_xf, 32);
                4: begin
                    chk("final_src_rdy", g, bus.TX_SRC_RDY, 0);
                    chk("final_status", g, bus.BUF_STATUS, 0);
                    chk("final_pending", g,
                        exq.size() + fq.size() + rdc.size(), 0);
                    chk("final_item_count", g, n_xf, pushed);
                end
                default: ;
            endcase
        end
    end

    initial begin
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2 target = 16;
        repeat (40) @(negedge clk);
        #2 ck_id = 1;
        ->ev_ck;
        mode   = 0;
        target = 32;
        repeat (15) @(negedge clk);
        #2 ck_id = 2;
        ->ev_ck;
        mode = 1;
        repeat (40) @(negedge clk);
        #2 ck_id = 3;
        ->ev_ck;
        mode     = 2;
        rnd_data = 1'b1;
        for (int i = 0; i < 2600; i++) begin
            @(negedge clk);
            #2;
            if (i == 300) begin
                rst_n  = 1'b0;
                target = 0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end else if (target < 1000 && $urandom_range(0, 9) < 4) begin
                target++;
            end
        end
        mode = 1;
        repeat (1500) @(negedge clk);
        #2 target++;
        repeat (12) @(negedge clk);
        #2 ck_id = 4;
        ->ev_ck;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
